spi_regbank_arb: RTL and testbench

Owner of the 32-bit register bank behind the SPI slave's register port. Arbitrates the bank between the SPI side, which is never stalled, and a system-side host port with a req/ack handshake. Tracks which registers the SPI master has written (dirty mask) and raises an interrupt so host software can react to SPI register writes. Sits between the SPI interface block's reg* signals and the on-chip processor bus adapter.

---
 rtl/spi_regbank_arb.sv | 143 ++++++++++++++
 tb/tb_spi_regbank_arb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regbank_arb.sv
// SPI-side register bank with a req/ack host port, collision stalls and dirty tracking.
// Define SPIREG_DIRTY_EN to build the dirty mask and irq; otherwise both are tied to 0.
module spi_regbank_arb #(
    parameter int                          RegAddrBits = 4,
    parameter logic [2**RegAddrBits-1:0]   SpiWrMask   = '0
) (
    input  logic                           SysClk,
    input  logic                           Reset,
    input  logic [RegAddrBits-1:0]         spi_regAddr,
    output logic [31:0]                    spi_regReadData,
    input  logic                           spi_regWriteEn,
    input  logic [31:0]                    spi_regWriteData,
    input  logic                           host_req,
    input  logic                           host_we,
    input  logic [RegAddrBits-1:0]         host_addr,
    input  logic [31:0]                    host_wdata,
    output logic                           host_ack,
    output logic [31:0]                    host_rdata,
    output logic [2**RegAddrBits-1:0]      dirty,
    output logic                           irq
);

    localparam int Depth = 2**RegAddrBits;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] bank [Depth];
    logic        spi_wr;
    logic        hit;
    logic        host_commit;
    logic        host_capture;

    // A masked SPI write neither commits nor collides with the host.
    assign spi_wr = spi_regWriteEn & ~SpiWrMask[spi_regAddr];
    assign hit    = spi_wr && (spi_regAddr == host_addr);

    assign spi_regReadData = bank[spi_regAddr];

    always_ff @(posedge SysClk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        host_ack     = 1'b0;
        host_commit  = 1'b0;
        host_capture = 1'b0;
        unique case (state)
            IDLE: begin
                if (host_req) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (host_we) begin
                    if (!hit) begin
                        host_commit = 1'b1;
                        state_nxt   = ACK;
                    end
                end else begin
                    host_capture = 1'b1;
                    state_nxt    = ACK;
                end
            end
            ACK: begin
                host_ack  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Host commit never coincides with an SPI write to the same entry.
    always_ff @(posedge SysClk) begin
        if (Reset) begin
            for (int i = 0; i < Depth; i++) begin
                bank[i] <= '0;
            end
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (host_commit && host_addr == RegAddrBits'(i)) begin
                    bank[i] <= host_wdata;
                end else if (spi_wr && spi_regAddr == RegAddrBits'(i)) begin
                    bank[i] <= spi_regWriteData;
                end
            end
        end
    end

    always_ff @(posedge SysClk) begin
        if (Reset) begin
            host_rdata <= '0;
        end else if (host_capture) begin
            host_rdata <= hit ? spi_regWriteData : bank[host_addr];
        end
    end

`ifdef SPIREG_DIRTY_EN
    logic [Depth-1:0] dirty_q;
    logic [Depth-1:0] dirty_nxt;
    logic             irq_q;

    // Clear first, then set, so an SPI write wins over a host read.
    always_comb begin
        dirty_nxt = dirty_q;
        if (host_capture) begin
            dirty_nxt[host_addr] = 1'b0;
        end
        if (spi_wr) begin
            dirty_nxt[spi_regAddr] = 1'b1;
        end
    end

    always_ff @(posedge SysClk) begin
        if (Reset) begin
            dirty_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            dirty_q <= dirty_nxt;
            irq_q   <= |dirty_nxt;
        end
    end

    assign dirty = dirty_q;
    assign irq   = irq_q;
`else
    assign dirty = '0;
    assign irq   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regbank_arb.sv
// Scoreboard bench for spi_regbank_arb: directed SPI/host traffic, monitor on host_ack.
// Dirty expectations follow SPIREG_DIRTY_EN as compiled.
module tb_spi_regbank_arb;

    localparam int AW = 4;
    localparam int D  = 16;
`ifdef SPIREG_DIRTY_EN
    localparam bit DE = 1'b1;
`else
    localparam bit DE = 1'b0;
`endif

    logic          SysClk = 1'b0;
    logic          Reset;
    logic [AW-1:0] spi_regAddr;
    logic [31:0]   spi_regReadData;
    logic          spi_regWriteEn;
    logic [31:0]   spi_regWriteData;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [31:0]   host_wdata;
    logic          host_ack;
    logic [31:0]   host_rdata;
    logic [D-1:0]  dirty;
    logic          irq;

    typedef struct {
        bit          rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    spi_regbank_arb #(
        .RegAddrBits(AW),
        .SpiWrMask  (16'h0002)
    ) dut (
        .SysClk          (SysClk),
        .Reset           (Reset),
        .spi_regAddr     (spi_regAddr),
        .spi_regReadData (spi_regReadData),
        .spi_regWriteEn  (spi_regWriteEn),
        .spi_regWriteData(spi_regWriteData),
        .host_req        (host_req),
        .host_we         (host_we),
        .host_addr       (host_addr),
        .host_wdata      (host_wdata),
        .host_ack        (host_ack),
        .host_rdata      (host_rdata),
        .dirty           (dirty),
        .irq             (irq)
    );

    always #5 SysClk = ~SysClk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called at a negedge; counts cycles with the request cycle as cycle 1.
    task automatic host_txn(input bit we, input logic [AW-1:0] a,
                            input logic [31:0] wd, input logic [31:0] exp_rd,
                            input int exp_lat, input string name);
        exp_t e;
        int   cyc;
        bit   got;
        e.rd   = !we;
        e.data = exp_rd;
        sb.push_back(e);
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = a;
        host_wdata = wd;
        cyc = 1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge SysClk);
            #1;
            cyc++;
            if (host_ack) got = 1'b1;
        end
        host_req = 1'b0;
        if (!got) begin
            void'(sb.pop_back());
            cyc = -1;
        end
        chk({name, "_latency"}, 32'(cyc), 32'(exp_lat));
        @(negedge SysClk);
    endtask

    task automatic spi_pulse(input logic [AW-1:0] a, input logic [31:0] d);
        spi_regWriteEn   = 1'b1;
        spi_regAddr      = a;
        spi_regWriteData = d;
        @(negedge SysClk);
        spi_regWriteEn = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge SysClk);
            if (host_ack) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack want none");
                end else begin
                    e = sb.pop_front();
                    if (e.rd) chk("host_rdata", host_rdata, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        Reset            = 1'b1;
        spi_regAddr      = '0;
        spi_regWriteEn   = 1'b0;
        spi_regWriteData = '0;
        host_req         = 1'b0;
        host_we          = 1'b0;
        host_addr        = '0;
        host_wdata       = '0;
        repeat (3) @(posedge SysClk);
        @(negedge SysClk);
        Reset = 1'b0;

        chk("rst_ack", 32'(host_ack), 32'h0);
        chk("rst_rdata", host_rdata, 32'h0);
        chk("rst_dirty", 32'(dirty), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        spi_regAddr = 4'd9;
        #1 chk("rst_bank9", spi_regReadData, 32'h0);

        host_txn(1'b0, 4'd3, 32'h0, 32'h0, 3, "rd3");
        chk("rd3_dirty", 32'(dirty), 32'h0);
        chk("rd3_irq", 32'(irq), 32'h0);

        spi_pulse(4'd5, 32'hDEADBEEF);
        #1 chk("spi5_rb", spi_regReadData, 32'hDEADBEEF);
        chk("spi5_dirty", 32'(dirty), DE ? 32'h0020 : 32'h0);
        chk("spi5_irq", 32'(irq), 32'(DE));
        @(negedge SysClk);
        host_txn(1'b0, 4'd5, 32'h0, 32'hDEADBEEF, 3, "rd5");
        chk("rd5_dirty", 32'(dirty), 32'h0);
        chk("rd5_irq", 32'(irq), 32'h0);

        fork
            host_txn(1'b1, 4'd2, 32'h11111111, 32'h0, 4, "wr2col");
            begin
                @(negedge SysClk);
                spi_pulse(4'd2, 32'h22222222);
            end
        join
        spi_regAddr = 4'd2;
        #1 chk("wr2col_bank", spi_regReadData, 32'h11111111);
        chk("wr2col_dirty", 32'(dirty), DE ? 32'h0004 : 32'h0);

        @(negedge SysClk);
        fork
            host_txn(1'b0, 4'd7, 32'h0, 32'hCAFEF00D, 3, "rd7fwd");
            begin
                @(negedge SysClk);
                spi_pulse(4'd7, 32'hCAFEF00D);
            end
        join
        chk("rd7_dirty", 32'(dirty), DE ? 32'h0084 : 32'h0);
        chk("rd7_irq", 32'(irq), 32'(DE));

        spi_pulse(4'd1, 32'hFFFFFFFF);
        spi_regAddr = 4'd1;
        #1 chk("mask1_bank", spi_regReadData, 32'h0);
        chk("mask1_dirty", 32'(dirty), DE ? 32'h0084 : 32'h0);
        @(negedge SysClk);
        host_txn(1'b1, 4'd1, 32'h5, 32'h0, 3, "wr1");
        #1 chk("wr1_bank", spi_regReadData, 32'h5);

        @(negedge SysClk);
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 4'd4;
        host_wdata = 32'hA5A5A5A5;
        @(negedge SysClk);
        Reset            = 1'b1;
        host_req         = 1'b0;
        spi_regWriteEn   = 1'b1;
        spi_regAddr      = 4'd6;
        spi_regWriteData = 32'h12345678;
        @(negedge SysClk);
        Reset          = 1'b0;
        spi_regWriteEn = 1'b0;
        seen = 0;
        repeat (4) begin
            @(posedge SysClk);
            #1;
            if (host_ack) seen = 1;
        end
        chk("rstmid_noack", 32'(seen), 32'h0);
        spi_regAddr = 4'd4;
        #1 chk("rstmid_bank4", spi_regReadData, 32'h0);
        spi_regAddr = 4'd6;
        #1 chk("rstmid_bank6", spi_regReadData, 32'h0);
        spi_regAddr = 4'd5;
        #1 chk("rstmid_bank5", spi_regReadData, 32'h0);
        chk("rstmid_dirty", 32'(dirty), 32'h0);
        chk("rstmid_irq", 32'(irq), 32'h0);
        chk("rstmid_rdata", host_rdata, 32'h0);
        @(negedge SysClk);
        host_txn(1'b0, 4'd4, 32'h0, 32'h0, 3, "rd4_idle");

        repeat (2) @(negedge SysClk);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
